// File: rtl/tuple_pkt_sync_pkg.sv
// rtl/tuple_pkt_sync_pkg.sv - shared encodings and stream widths for the tuple/packet synchroniser
package tuple_pkt_sync_pkg;

    localparam int DATA_W  = 256;
    localparam int KEEP_W  = 32;
    localparam int TUPLE_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PASS = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

endpackage

// File: rtl/tuple_fifo.sv
// rtl/tuple_fifo.sv - synchronous FIFO with extra-MSB wrap pointers; push while full is ignored
module tuple_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // a same-cycle pop frees the slot, so a push into a full FIFO still lands
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/tuple_pkt_sync.sv
// rtl/tuple_pkt_sync.sv - holds each packet until its tuple is queued, then passes it with the tuple held stable
module tuple_pkt_sync
    import tuple_pkt_sync_pkg::*;
#(
    parameter int TUPLE_DEPTH = 4,
    parameter int CNT_W       = 16
) (
    input  logic               tsync_aclk,
    input  logic               tsync_arst,
    input  logic               tsync_avalid,
    output logic               tsync_aready,
    input  logic [DATA_W-1:0]  tsync_adata,
    input  logic [KEEP_W-1:0]  tsync_akeep,
    input  logic               tsync_atlast,
    input  logic               tsync_tvalid,
    input  logic [TUPLE_W-1:0] tsync_tdata,
    output logic               tsync_bvalid,
    input  logic               tsync_bready,
    output logic [DATA_W-1:0]  tsync_bdata,
    output logic [KEEP_W-1:0]  tsync_bkeep,
    output logic               tsync_btlast,
    output logic               tsync_tout_valid,
    output logic [TUPLE_W-1:0] tsync_tout_data,
    output logic               tsync_ovf,
    output logic [CNT_W-1:0]   tsync_pkt_cnt,
    output logic [CNT_W-1:0]   tsync_drop_cnt,
    output logic [1:0]         dbg_state
);

    state_t             state;
    state_t             state_nxt;
    logic [TUPLE_W-1:0] fifo_head;
    logic               fifo_empty;
    logic               fifo_full;
    logic               load_tuple;
    logic               xfer_last;
    logic               drop;

    assign load_tuple = (state == ST_IDLE) && !fifo_empty;
    assign xfer_last  = (state == ST_PASS) && tsync_avalid && tsync_bready && tsync_atlast && !tsync_arst;
    assign drop       = tsync_tvalid && fifo_full && !xfer_last;

    tuple_fifo #(
        .WIDTH (TUPLE_W),
        .DEPTH (TUPLE_DEPTH)
    ) u_tuple_fifo (
        .clk   (tsync_aclk),
        .rst   (tsync_arst),
        .push  (tsync_tvalid),
        .din   (tsync_tdata),
        .pop   (xfer_last),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign tsync_bdata  = tsync_adata;
    assign tsync_bkeep  = tsync_akeep;
    assign tsync_btlast = tsync_atlast;
    assign dbg_state    = state;

    always_ff @(posedge tsync_aclk) begin
        if (tsync_arst) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        tsync_aready = 1'b0;
        tsync_bvalid = 1'b0;
        case (state)
            ST_IDLE: if (!fifo_empty) state_nxt = ST_PASS;
            ST_PASS: begin
                tsync_bvalid = tsync_avalid;
                tsync_aready = tsync_bready;
                if (xfer_last) state_nxt = ST_GAP;
            end
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        // a reset cycle mid-packet must not forward the beat on the wires
        if (tsync_arst) begin
            tsync_aready = 1'b0;
            tsync_bvalid = 1'b0;
        end
    end

    always_ff @(posedge tsync_aclk) begin
        if (tsync_arst) begin
            tsync_tout_valid <= 1'b0;
            tsync_tout_data  <= '0;
            tsync_ovf        <= 1'b0;
            tsync_pkt_cnt    <= '0;
            tsync_drop_cnt   <= '0;
        end else begin
            // head is copied once at packet start so later pushes cannot disturb it
            if (load_tuple) begin
                tsync_tout_data  <= fifo_head;
                tsync_tout_valid <= 1'b1;
            end
            if (xfer_last) begin
                tsync_tout_valid <= 1'b0;
                tsync_pkt_cnt    <= tsync_pkt_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (drop) begin
                tsync_ovf <= 1'b1;
                if (tsync_drop_cnt != {CNT_W{1'b1}})
                    tsync_drop_cnt <= tsync_drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: doc/tuple_pkt_sync.md
Name: tuple_pkt_sync

Overview:
- Sits directly upstream of the tuser-attach output stage, between the SDNet engine outputs and that stage.
- The engine emits the 256-bit packet stream and a 128-bit tuple, a single-cycle valid pulse, with arbitrary relative timing.
- This block queues tuples, releases each packet only once its tuple is available, and holds that tuple stable for every beat of the packet.
- It also reports tuple overflow and forwarded-packet statistics.

Parameters:
- TUPLE_DEPTH, 4: tuple FIFO entries; power of two, minimum 2.
- CNT_W, 16: width of the packet and drop counters.

Ports:
- tsync_aclk  in  1  clock
- tsync_arst  in  1  synchronous active-high reset
- tsync_avalid  in  1  input packet beat valid
- tsync_aready  out  1  input packet beat ready
- tsync_adata  in  256  input packet data
- tsync_akeep  in  32  input byte enables
- tsync_atlast  in  1  input last beat
- tsync_tvalid  in  1  tuple valid pulse from engine
- tsync_tdata  in  128  tuple from engine
- tsync_bvalid  out  1  output beat valid
- tsync_bready  in  1  output beat ready
- tsync_bdata  out  256  output data
- tsync_bkeep  out  32  output byte enables
- tsync_btlast  out  1  output last beat
- tsync_tout_valid  out  1  tuple valid toward the downstream stage
- tsync_tout_data  out  128  tuple toward the downstream stage, stable for the whole packet
- tsync_ovf  out  1  sticky tuple-overflow flag
- tsync_pkt_cnt  out  CNT_W  packets forwarded
- tsync_drop_cnt  out  CNT_W  tuples dropped
- dbg_state  out  2  FSM state

Behaviour:
- Clock and reset: one clock, tsync_aclk. tsync_arst is synchronous and active-high.
- Reset values:
  - FIFO empty, state IDLE.
  - tsync_aready=0, tsync_bvalid=0.
  - tsync_tout_valid=0, tsync_tout_data=0.
  - tsync_ovf=0, both counters 0.
- Reset mid-packet: the packet is abandoned and no beat is forwarded that cycle. Upstream shares the reset, so no remnant beats follow.
- Tuple FIFO:
  - Push when tsync_tvalid=1 and (not full, or a pop occurs the same cycle).
  - Push while full with no pop: tuple discarded, tsync_ovf set (sticky until reset), tsync_drop_cnt incremented, saturating at all-ones.
  - Read and write pointers are log2(TUPLE_DEPTH)+1 bits and wrap naturally. Full when the MSBs differ and the LSBs are equal.
- FSM, 2 bits:
  - IDLE=00: tsync_aready=0 and tsync_bvalid=0. If the FIFO is non-empty, load tsync_tout_data from the FIFO head, set tsync_tout_valid=1, go to PASS. The head is not popped yet. Latency from a tuple push into an empty FIFO to tsync_tout_valid=1 is 2 cycles.
  - PASS=01: data path is combinational pass-through.
    - tsync_bvalid = tsync_avalid.
    - tsync_aready = tsync_bready.
    - bdata, bkeep and btlast mirror adata, akeep and atlast.
    - A beat transfers when tsync_avalid and tsync_bready are both 1.
    - On a transfer with tsync_atlast=1: pop the FIFO, increment tsync_pkt_cnt (wraps), go to GAP.
  - GAP=10: one bubble cycle. tsync_tout_valid=0, aready=0, bvalid=0; then go to IDLE. This gives the downstream FSM an idle cycle between packets.
  - 11: unreachable; go to IDLE.
- Packet arrives before its tuple: the block stays in IDLE with tsync_aready=0. Beats stall upstream and no data is lost.
- tsync_tout_data must not change between IDLE→PASS and the GAP exit, even if tuples are pushed meanwhile.
- A tuple push and the last-beat pop in the same cycle: both take effect, and the count is unchanged.
- Single-beat packet (tlast on the first beat) is legal: one cycle in PASS when bready=1.

Decomposition:
- Shared package:
  - state encodings IDLE, PASS, GAP
  - AXIS width constants DATA_W=256, KEEP_W=32, TUPLE_W=128
- One sub-module: tuple_fifo, a synchronous FIFO parameterised by width and depth.
  - Outputs: head data, empty, full.
  - Push-when-full is ignored inside the FIFO; the overflow flag and drop counter are handled in the parent.

Test Plan:
- Tuple 0xA5..A5 pushed, then a 3-beat packet 2 cycles later with bready=1 → tout_data=0xA5..A5 on all 3 output beats, btlast on beat 3, pkt_cnt=1, FSM sequence IDLE→PASS→GAP→IDLE.
- 4-beat packet presented 10 cycles before its tuple → tsync_aready=0 for the entire wait; the first beat transfers 2 cycles after tuple push at the earliest; data and keep match input exactly.
- bready toggled 1/0 every cycle during a 5-beat packet → no beat dropped or duplicated, tout_data stable throughout, aready tracks bready.
- With TUPLE_DEPTH=4 and no packets, 5 tuples pushed on consecutive cycles → first 4 retained in order, ovf=1, drop_cnt=1; then 4 single-beat packets carry tuples 1..4 in order.
- FIFO full and last beat accepted in the same cycle as a new tuple push → no drop, ovf stays 0, next packet gets the former second entry.
- Reset asserted during beat 2 of a 4-beat packet → next cycle all outputs at reset values, FIFO empty, pkt_cnt=0; a subsequent tuple plus packet forwards normally.
